// File: rtl/axi_video_scanout_pkg.sv
// -----------------------------------------------------------------------------
// axi_video_scanout_pkg
// Shared types and constants for the framebuffer scanout block.
//   fetch_state_t   : fetch FSM state encoding
//   AXI_AR*         : fixed AR channel field values
//   grey_of()       : luma approximation used when AXI_VIDEO_SCANOUT_GREY_EN
//                     is defined
// -----------------------------------------------------------------------------
package axi_video_scanout_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_FLUSH
   } fetch_state_t;

   localparam logic [2:0] AXI_ARSIZE       = 3'h2;   // 4-byte beats
   localparam logic [1:0] AXI_ARBURST_INCR = 2'b01;
   localparam logic [3:0] AXI_ARCACHE      = 4'h2;   // normal, non-cacheable

   // (77*R + 150*G + 29*B) >> 8 in a 16-bit unsigned intermediate.
   function automatic logic [7:0] grey_of(input logic [23:0] rgb);
      logic [15:0] sum;
      sum = 16'd77  * {8'd0, rgb[23:16]}
          + 16'd150 * {8'd0, rgb[15:8]}
          + 16'd29  * {8'd0, rgb[7:0]};
      return sum[15:8];
   endfunction

endpackage

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
// Raster counters and combinational timing decode.
// Ports:
//   m_axi_aclk, m_axi_aresetn : clock, synchronous active-low reset
//   scan_enable               : run/stop; while low the counters are parked at
//                               h=0, v=V_ACTIVE+V_FP and all outputs are 0
//   h_cnt, v_cnt              : raster position
//   active, hsync, vsync      : decoded timing (unregistered)
//   frame_start               : first cycle of the first vsync line
// -----------------------------------------------------------------------------
module video_timing_gen #(
   parameter int H_ACTIVE = 1920,
   parameter int H_FP     = 88,
   parameter int H_SYNC   = 44,
   parameter int H_BP     = 148,
   parameter int V_ACTIVE = 1080,
   parameter int V_FP     = 4,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 36,
   parameter int CW       = 12
) (
   input  logic          m_axi_aclk,
   input  logic          m_axi_aresetn,
   input  logic          scan_enable,
   output logic [CW-1:0] h_cnt,
   output logic [CW-1:0] v_cnt,
   output logic          active,
   output logic          hsync,
   output logic          vsync,
   output logic          frame_start
);

   localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] H_LAST = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CW-1:0] V_LAST = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

   // Parking at the vsync line start makes frame_start fire on the first
   // enabled cycle, so prefetch overlaps vertical blanking.
   always_ff @(posedge m_axi_aclk) begin
      // NOTE: non-blocking assignments for all clocked state so every reader
      // sees the pre-edge value regardless of process ordering.
      if (!m_axi_aresetn || !scan_enable) begin
         h_cnt <= '0;
         v_cnt <= VS_BEG;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);
      end else begin
         h_cnt <= h_cnt + CW'(1);
      end
   end

   assign active      = scan_enable && (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign hsync       = scan_enable && (h_cnt >= HS_BEG) && (h_cnt < HS_END);
   assign vsync       = scan_enable && (v_cnt >= VS_BEG) && (v_cnt < VS_END);
   assign frame_start = scan_enable && (h_cnt == '0) && (v_cnt == VS_BEG);

endmodule

// File: rtl/axi_video_scanout.sv
// -----------------------------------------------------------------------------
// axi_video_scanout
// Fetches 24-bit pixels (one per 32-bit word) from a bottom-up framebuffer with
// AXI INCR read bursts, buffers them in a FWFT FIFO and emits a top-first
// raster with hsync/vsync/de.
// Ports:
//   m_axi_aclk, m_axi_aresetn : sole clock (pixel rate), sync active-low reset
//   m_axi_ar* / m_axi_r*      : AXI4 read address / read data channels
//   scan_enable               : run/stop control
//   vid_hsync/vsync/de/data   : registered video output
//   scan_underflow            : sticky, de while FIFO empty (clears when !scan_enable)
//   scan_rd_error             : sticky, rresp != 0 seen (clears when !scan_enable)
// Build option: define AXI_VIDEO_SCANOUT_GREY_EN for greyscale output with one
// extra pipeline stage on all vid_* signals.
// -----------------------------------------------------------------------------
module axi_video_scanout
   import axi_video_scanout_pkg::*;
#(
   parameter logic [31:0] C_M_AXI_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
   parameter int H_ACTIVE   = 1920,
   parameter int H_FP       = 88,
   parameter int H_SYNC     = 44,
   parameter int H_BP       = 148,
   parameter int V_ACTIVE   = 1080,
   parameter int V_FP       = 4,
   parameter int V_SYNC     = 5,
   parameter int V_BP       = 36,
   parameter int BURST_LEN  = 16,
   parameter int FIFO_DEPTH = 64
) (
   input  logic        m_axi_aclk,
   input  logic        m_axi_aresetn,
   output logic [31:0] m_axi_araddr,
   output logic [7:0]  m_axi_arlen,
   output logic [2:0]  m_axi_arsize,
   output logic [1:0]  m_axi_arburst,
   output logic        m_axi_arlock,
   output logic [3:0]  m_axi_arcache,
   output logic [2:0]  m_axi_arprot,
   output logic [3:0]  m_axi_arqos,
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   input  logic [31:0] m_axi_rdata,
   input  logic [1:0]  m_axi_rresp,
   input  logic        m_axi_rlast,
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready,
   input  logic        scan_enable,
   output logic        vid_hsync,
   output logic        vid_vsync,
   output logic        vid_de,
   output logic [23:0] vid_data,
   output logic        scan_underflow,
   output logic        scan_rd_error
);

   localparam int CW = 12;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]   SPACE_LIMIT = (AW+1)'(FIFO_DEPTH - BURST_LEN);
   localparam logic [23:0]   BURSTS_PER_FRAME = 24'(H_ACTIVE * V_ACTIVE / BURST_LEN);
   localparam logic [CW-1:0] LAST_BURST_X = CW'(H_ACTIVE / BURST_LEN - 1);
   localparam logic [31:0]   LINE0_ADDR = C_M_AXI_TARGET_SLAVE_BASE_ADDR
                                        + 32'(4 * H_ACTIVE * (V_ACTIVE - 1));
   localparam logic [31:0]   BURST_BYTES = 32'(4 * BURST_LEN);
   // Last burst of a line: step past it, then back two lines (one to reach
   // this line's start, one more for the line above it in memory).
   localparam logic [31:0]   LINE_BACK = 32'(8 * H_ACTIVE);

   // ---------------- timing ----------------
   logic [CW-1:0] h_cnt, v_cnt;
   logic          active, hsync, vsync, frame_start;

   video_timing_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .CW(CW)
   ) u_timing (
      .m_axi_aclk   (m_axi_aclk),
      .m_axi_aresetn(m_axi_aresetn),
      .scan_enable  (scan_enable),
      .h_cnt        (h_cnt),
      .v_cnt        (v_cnt),
      .active       (active),
      .hsync        (hsync),
      .vsync        (vsync),
      .frame_start  (frame_start)
   );

   // ---------------- fetch FSM ----------------
   fetch_state_t  state, state_nxt;
   logic          arvalid_q, flush_pending;
   logic [31:0]   cur_addr;
   logic [CW-1:0] burst_x;
   logic [23:0]   bursts_left;
   logic [AW:0]   fifo_count;
   logic          push, pop, can_issue, ar_hs;

   assign ar_hs = arvalid_q && m_axi_arready;
   assign push  = m_axi_rvalid && m_axi_rready && !flush_pending;
   assign pop   = active && (fifo_count != '0);

   // The space check includes a beat landing this cycle so the same check can
   // chain straight from the rlast beat into the next burst.
   assign can_issue = ((fifo_count + {{AW{1'b0}}, push}) <= SPACE_LIMIT)
                    && (bursts_left != '0) && !flush_pending && !frame_start
                    && scan_enable;

   always_comb begin
      // NOTE: default first so no path through the case infers a latch.
      state_nxt = state;
      case (state)
         ST_IDLE:  if (flush_pending)  state_nxt = ST_FLUSH;
                   else if (can_issue) state_nxt = ST_ADDR;
         ST_ADDR:  if (ar_hs)          state_nxt = ST_DATA;
         ST_DATA:  if (m_axi_rvalid && m_axi_rlast)
                      state_nxt = can_issue ? ST_ADDR : ST_IDLE;
         ST_FLUSH: state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge m_axi_aclk) begin
      if (!m_axi_aresetn) begin
         state         <= ST_IDLE;
         arvalid_q     <= 1'b0;
         flush_pending <= 1'b0;
         cur_addr      <= C_M_AXI_TARGET_SLAVE_BASE_ADDR;
         burst_x       <= '0;
         bursts_left   <= '0;
      end else begin
         state <= state_nxt;
         if (frame_start)            flush_pending <= 1'b1;
         else if (state == ST_FLUSH) flush_pending <= 1'b0;
         // Registered valid: rises the cycle after ADDR is entered.
         if (ar_hs)                  arvalid_q <= 1'b0;
         else if (state == ST_ADDR)  arvalid_q <= 1'b1;
         if (state == ST_FLUSH) begin
            cur_addr    <= LINE0_ADDR;
            burst_x     <= '0;
            bursts_left <= BURSTS_PER_FRAME;
         end else if (ar_hs) begin
            bursts_left <= bursts_left - 24'd1;
            if (burst_x == LAST_BURST_X) begin
               burst_x  <= '0;
               cur_addr <= cur_addr + BURST_BYTES - LINE_BACK;
            end else begin
               burst_x  <= burst_x + CW'(1);
               cur_addr <= cur_addr + BURST_BYTES;
            end
         end
      end
   end

   assign m_axi_araddr  = cur_addr;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = (state == ST_DATA);
   assign m_axi_arlen   = 8'(BURST_LEN - 1);
   assign m_axi_arsize  = AXI_ARSIZE;
   assign m_axi_arburst = AXI_ARBURST_INCR;
   assign m_axi_arlock  = 1'b0;
   assign m_axi_arcache = AXI_ARCACHE;
   assign m_axi_arprot  = 3'h0;
   assign m_axi_arqos   = 4'h0;

   // ---------------- pixel FIFO (first-word-fall-through) ----------------
   logic [23:0]   fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;

   // NOTE: storage is deliberately not reset; occupancy is tracked by the
   // pointers and count, which are.
   always_ff @(posedge m_axi_aclk) begin
      if (push) fifo_mem[wr_ptr] <= m_axi_rdata[23:0];
   end

   always_ff @(posedge m_axi_aclk) begin
      if (!m_axi_aresetn || state == ST_FLUSH) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      fifo_count <= fifo_count + (AW+1)'(1);
         else if (pop && !push) fifo_count <= fifo_count - (AW+1)'(1);
      end
   end

   // ---------------- output stage ----------------
   logic        s_hsync, s_vsync, s_de;
   logic [23:0] s_data;

   always_ff @(posedge m_axi_aclk) begin
      if (!m_axi_aresetn) begin
         s_hsync <= 1'b0;
         s_vsync <= 1'b0;
         s_de    <= 1'b0;
         s_data  <= '0;
      end else begin
         s_hsync <= hsync;
         s_vsync <= vsync;
         s_de    <= active;
         s_data  <= pop ? fifo_mem[rd_ptr] : '0;
      end
   end

   always_ff @(posedge m_axi_aclk) begin
      if (!m_axi_aresetn || !scan_enable) begin
         scan_underflow <= 1'b0;
         scan_rd_error  <= 1'b0;
      end else begin
         if (active && fifo_count == '0) scan_underflow <= 1'b1;
         if (m_axi_rvalid && m_axi_rready && m_axi_rresp != 2'b00) scan_rd_error <= 1'b1;
      end
   end

`ifdef AXI_VIDEO_SCANOUT_GREY_EN
   logic       g_hsync, g_vsync, g_de;
   logic [7:0] g_luma;

   always_ff @(posedge m_axi_aclk) begin
      if (!m_axi_aresetn) begin
         g_hsync <= 1'b0;
         g_vsync <= 1'b0;
         g_de    <= 1'b0;
         g_luma  <= '0;
      end else begin
         g_hsync <= s_hsync;
         g_vsync <= s_vsync;
         g_de    <= s_de;
         g_luma  <= grey_of(s_data);
      end
   end

   assign vid_hsync = g_hsync;
   assign vid_vsync = g_vsync;
   assign vid_de    = g_de;
   assign vid_data  = {3{g_luma}};
`else
   assign vid_hsync = s_hsync;
   assign vid_vsync = s_vsync;
   assign vid_de    = s_de;
   assign vid_data  = s_data;
`endif

   // Alpha byte and raster position are not needed here.
   logic unused_ok;
   assign unused_ok = &{1'b0, m_axi_rdata[31:24], h_cnt, v_cnt};

endmodule

// File: tb/tb_axi_video_scanout.sv
// -----------------------------------------------------------------------------
// tb_axi_video_scanout
// Directed bench for axi_video_scanout on a 16x4 raster with a zero-wait AXI
// read slave. Word at address a is {8'hEE, a[7:0]^8'h3C, a[15:8], a[7:0]}.
// -----------------------------------------------------------------------------
module tb_axi_video_scanout;

   localparam logic [31:0] BASE = 32'h4000_0000;
   localparam int HA = 16, HF = 2, HS = 2, HB = 4;
   localparam int VA = 4,  VF = 1, VS = 1, VB = 2;
   localparam int BL = 4,  FD = 16;
   localparam int HT = HA + HF + HS + HB;   // 24
   localparam int VT = VA + VF + VS + VB;   // 8
   localparam int FRAME = HT * VT;          // 192

   logic        m_axi_aclk = 1'b0;
   logic        m_axi_aresetn;
   logic [31:0] m_axi_araddr;
   logic [7:0]  m_axi_arlen;
   logic [2:0]  m_axi_arsize;
   logic [1:0]  m_axi_arburst;
   logic        m_axi_arlock;
   logic [3:0]  m_axi_arcache;
   logic [2:0]  m_axi_arprot;
   logic [3:0]  m_axi_arqos;
   logic        m_axi_arvalid;
   logic        m_axi_arready;
   logic [31:0] m_axi_rdata;
   logic [1:0]  m_axi_rresp;
   logic        m_axi_rlast;
   logic        m_axi_rvalid;
   logic        m_axi_rready;
   logic        scan_enable;
   logic        vid_hsync, vid_vsync, vid_de;
   logic [23:0] vid_data;
   logic        scan_underflow, scan_rd_error;

   axi_video_scanout #(
      .C_M_AXI_TARGET_SLAVE_BASE_ADDR(BASE),
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .BURST_LEN(BL), .FIFO_DEPTH(FD)
   ) dut (
      .m_axi_aclk    (m_axi_aclk),
      .m_axi_aresetn (m_axi_aresetn),
      .m_axi_araddr  (m_axi_araddr),
      .m_axi_arlen   (m_axi_arlen),
      .m_axi_arsize  (m_axi_arsize),
      .m_axi_arburst (m_axi_arburst),
      .m_axi_arlock  (m_axi_arlock),
      .m_axi_arcache (m_axi_arcache),
      .m_axi_arprot  (m_axi_arprot),
      .m_axi_arqos   (m_axi_arqos),
      .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (m_axi_arready),
      .m_axi_rdata   (m_axi_rdata),
      .m_axi_rresp   (m_axi_rresp),
      .m_axi_rlast   (m_axi_rlast),
      .m_axi_rvalid  (m_axi_rvalid),
      .m_axi_rready  (m_axi_rready),
      .scan_enable   (scan_enable),
      .vid_hsync     (vid_hsync),
      .vid_vsync     (vid_vsync),
      .vid_de        (vid_de),
      .vid_data      (vid_data),
      .scan_underflow(scan_underflow),
      .scan_rd_error (scan_rd_error)
   );

   always #5 m_axi_aclk = ~m_axi_aclk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {8'hEE, a[7:0] ^ 8'h3C, a[15:8], a[7:0]};
   endfunction

   // Expected displayed pixel for the word at address a.
   function automatic logic [23:0] px(input logic [31:0] a);
      logic [31:0] w;
      int y;
      w = mem_word(a);
`ifdef AXI_VIDEO_SCANOUT_GREY_EN
      y = (77 * int'(w[23:16]) + 150 * int'(w[15:8]) + 29 * int'(w[7:0])) / 256;
      return {3{y[7:0]}};
`else
      y = 0;
      return w[23:0] | 24'(y);
`endif
   endfunction

   // ---------------- zero-wait AXI read slave ----------------
   logic [31:0] ar_log[$];
   logic [7:0]  arlen_log[$];
   logic [31:0] err_addr   = 32'hFFFF_FFFF;
   logic        arready_en = 1'b1;

   task automatic drive_beat(input logic [31:0] a, input int beat);
      m_axi_rdata = mem_word(a);
      m_axi_rresp = (a == err_addr) ? 2'b10 : 2'b00;
      m_axi_rlast = (beat == BL - 1);
   endtask

   initial begin : slave
      logic        ar_hs, r_hs, last;
      logic [31:0] ar_a, b_addr;
      int          beat;
      m_axi_arready = 1'b0;
      m_axi_rvalid  = 1'b0;
      m_axi_rlast   = 1'b0;
      m_axi_rdata   = '0;
      m_axi_rresp   = 2'b00;
      beat   = 0;
      b_addr = '0;
      forever begin
         @(negedge m_axi_aclk);
         m_axi_arready = arready_en;
         ar_hs = m_axi_arvalid && m_axi_arready;
         r_hs  = m_axi_rvalid && m_axi_rready;
         last  = m_axi_rlast;
         ar_a  = m_axi_araddr;
         if (ar_hs) begin
            ar_log.push_back(ar_a);
            arlen_log.push_back(m_axi_arlen);
         end
         @(posedge m_axi_aclk);
         #1;
         if (r_hs) begin
            if (last) begin
               m_axi_rvalid = 1'b0;
               m_axi_rlast  = 1'b0;
            end else begin
               beat++;
               b_addr = b_addr + 32'd4;
               drive_beat(b_addr, beat);
            end
         end
         if (ar_hs) begin
            beat   = 0;
            b_addr = ar_a;
            m_axi_rvalid = 1'b1;
            drive_beat(b_addr, beat);
         end
      end
   end

   function automatic logic [31:0] ar_at(input int i);
      return (ar_log.size() > i) ? ar_log[i] : 32'hDEAD_BEEF;
   endfunction

   // ---------------- frame measurement ----------------
   // Window starts at the vsync rising edge: 1 vsync line, 2 back-porch lines,
   // 4 active lines (screen 0..3), 1 front-porch line.
   task automatic run_frame(input bit expect_zero,
                            output int hs_n, output int vs_n, output int de_n,
                            output int bad_px, output int bad_hs_per,
                            output int vs_again, output logic [23:0] first_px);
      bit   prev, found;
      int   n, last_rise;
      logic [23:0] exp;
      hs_n = 0; vs_n = 0; de_n = 0; bad_px = 0; bad_hs_per = 0; vs_again = 0;
      first_px = 24'hBADBAD;
      found = 0;
      prev  = 1'b1;
      for (int i = 0; i < 4 * FRAME && !found; i++) begin
         @(negedge m_axi_aclk);
         if (vid_vsync && !prev) found = 1;
         prev = vid_vsync;
      end
      check("vsync_seen", 32'(found), 32'd1);
      if (!found) return;
      n = 0;
      last_rise = -1;
      prev = 1'b0;
      for (int i = 0; i < FRAME; i++) begin
         if (i > 0) @(negedge m_axi_aclk);
         if (vid_hsync) hs_n++;
         if (vid_vsync) vs_n++;
         if (vid_hsync && !prev) begin
            if (last_rise >= 0 && i - last_rise != HT) bad_hs_per++;
            last_rise = i;
         end
         prev = vid_hsync;
         if (vid_de) begin
            exp = expect_zero ? 24'h0
                : px(BASE + 32'(4 * (HA * (VA - 1 - (n / HA)) + (n % HA))));
            if (n == 0) first_px = vid_data;
            if (vid_data !== exp) bad_px++;
            n++;
            de_n++;
         end
      end
      @(negedge m_axi_aclk);
      vs_again = int'(vid_vsync);
   endtask

   task automatic stop_scan();
      @(negedge m_axi_aclk);
      scan_enable = 1'b0;
      repeat (3) @(negedge m_axi_aclk);
   endtask

   // ---------------- main sequence ----------------
   initial begin : main
      int hs_n, vs_n, de_n, bad_px, bad_hs, vs_again;
      logic [23:0] first_px;

      scan_enable   = 1'b1;
      m_axi_aresetn = 1'b0;
      repeat (4) @(negedge m_axi_aclk);
      check("rst_arvalid",   32'(m_axi_arvalid),  32'd0);
      check("rst_rready",    32'(m_axi_rready),   32'd0);
      check("rst_araddr",    m_axi_araddr,        BASE);
      check("rst_hsync",     32'(vid_hsync),      32'd0);
      check("rst_vsync",     32'(vid_vsync),      32'd0);
      check("rst_de",        32'(vid_de),         32'd0);
      check("rst_data",      32'(vid_data),       32'd0);
      check("rst_underflow", 32'(scan_underflow), 32'd0);
      check("rst_rd_error",  32'(scan_rd_error),  32'd0);

      // Free-running from reset release.
      ar_log.delete();
      arlen_log.delete();
      m_axi_aresetn = 1'b1;
      run_frame(1'b0, hs_n, vs_n, de_n, bad_px, bad_hs, vs_again, first_px);
      check("first_ar_addr",  ar_at(0), BASE + 32'hC0);
      check("second_ar_addr", ar_at(1), BASE + 32'hD0);
      check("line1_ar_addr",  ar_at(4), BASE + 32'h80);
      check("last_ar_addr",   ar_at(15), BASE + 32'h30);
      check("first_arlen",    32'((arlen_log.size() > 0) ? arlen_log[0] : 8'hFF), 32'd3);
      check("arsize",         32'(m_axi_arsize),  32'd2);
      check("arburst",        32'(m_axi_arburst), 32'd1);
      check("arcache",        32'(m_axi_arcache), 32'd2);
      check("arlock_prot_qos", {24'd0, m_axi_arlock, m_axi_arprot, m_axi_arqos}, 32'd0);
      check("first_de_pixel", 32'(first_px), 32'(px(BASE + 32'hC0)));
      check("hsync_cycles",   32'(hs_n),  32'd16);
      check("hsync_period",   32'(bad_hs), 32'd0);
      check("vsync_cycles",   32'(vs_n),  32'd24);
      check("vsync_period",   32'(vs_again), 32'd1);
      check("de_cycles",      32'(de_n),  32'd64);
      check("frame0_pixels",  32'(bad_px), 32'd0);
      check("no_underflow",   32'(scan_underflow), 32'd0);
      check("no_rd_error",    32'(scan_rd_error),  32'd0);

      // Second frame exercises pointer reload and flush across frames.
      run_frame(1'b0, hs_n, vs_n, de_n, bad_px, bad_hs, vs_again, first_px);
      check("frame1_pixels",  32'(bad_px), 32'd0);
      check("frame1_de",      32'(de_n),  32'd64);

      // Disable: outputs quiet.
      stop_scan();
      check("off_hsync", 32'(vid_hsync), 32'd0);
      check("off_vsync", 32'(vid_vsync), 32'd0);
      check("off_de",    32'(vid_de),    32'd0);
      check("off_data",  32'(vid_data),  32'd0);
      repeat (20) @(negedge m_axi_aclk);

      // Read error on screen line 0 pixel 1: flagged, pixel still shown.
      err_addr = BASE + 32'hC4;
      scan_enable = 1'b1;
      run_frame(1'b0, hs_n, vs_n, de_n, bad_px, bad_hs, vs_again, first_px);
      check("rd_error_set",   32'(scan_rd_error), 32'd1);
      check("rd_error_pixels", 32'(bad_px), 32'd0);
      err_addr = 32'hFFFF_FFFF;
      stop_scan();
      check("rd_error_clear", 32'(scan_rd_error), 32'd0);
      repeat (20) @(negedge m_axi_aclk);

      // Starved memory: black pixels during de and sticky underflow.
      arready_en = 1'b0;
      repeat (2) @(negedge m_axi_aclk);
      scan_enable = 1'b1;
      run_frame(1'b1, hs_n, vs_n, de_n, bad_px, bad_hs, vs_again, first_px);
      check("starve_black",    32'(bad_px), 32'd0);
      check("starve_de",       32'(de_n),  32'd64);
      check("underflow_set",   32'(scan_underflow), 32'd1);
      repeat (HT) @(negedge m_axi_aclk);
      check("underflow_held",  32'(scan_underflow), 32'd1);
      arready_en = 1'b1;
      stop_scan();
      check("underflow_clear", 32'(scan_underflow), 32'd0);
      repeat (20) @(negedge m_axi_aclk);
      check("idle_after_stop", 32'({m_axi_arvalid, m_axi_rready}), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/axi_video_scanout.md
# axi_video_scanout

Framebuffer scanout stage downstream of the BMP-to-memory loader. It fetches 24-bit pixels, stored one per 32-bit word with bits [23:0] = {R,G,B}, from the framebuffer in AXI memory using INCR read bursts. The pixels are buffered in an internal FIFO and emitted as a raster with hsync/vsync/de timing. Lines are read bottom-up, so the BMP row order is flipped to top-first on screen.

## Interface
- C_M_AXI_TARGET_SLAVE_BASE_ADDR, 32'h40000000, framebuffer base address.
- H_ACTIVE/H_FP/H_SYNC/H_BP, 1920/88/44/148, horizontal timing in cycles.
- V_ACTIVE/V_FP/V_SYNC/V_BP, 1080/4/5/36, vertical timing in lines.
- BURST_LEN, 16, beats per burst. H_ACTIVE must be a multiple of BURST_LEN.
- FIFO_DEPTH, 64, pixel FIFO depth. Power of 2, at least 2*BURST_LEN.

Ports:
- m_axi_aclk  in  1  sole clock; pixel rate equals this clock.
- m_axi_aresetn  in  1  reset, synchronous, active-low.
- m_axi_araddr out 32; m_axi_arlen out 8; m_axi_arsize out 3; m_axi_arburst out 2; m_axi_arlock out 1; m_axi_arcache out 4; m_axi_arprot out 3; m_axi_arqos out 4; m_axi_arvalid out 1; m_axi_arready in 1  AR channel.
- m_axi_rdata in 32; m_axi_rresp in 2; m_axi_rlast in 1; m_axi_rvalid in 1; m_axi_rready out 1  R channel.
- scan_enable  in  1  run/stop control.
- vid_hsync, vid_vsync, vid_de  out  1 each  active-high sync and data-enable.
- vid_data  out  24  pixel {R,G,B}.
- scan_underflow  out  1  sticky: de was asserted while the FIFO was empty.
- scan_rd_error  out  1  sticky: some beat had rresp != 0.

## Operation
- Constant AR fields:
  - arlen = BURST_LEN-1, arsize = 3'h2, arburst = INCR.
  - arlock = 0, arcache = 4'h2, arprot = 0, arqos = 0.
- Timing counters h_cnt in 0..H_TOTAL-1 and v_cnt in 0..V_TOTAL-1. H_TOTAL and V_TOTAL are the sums of their four parameters.
- Active region is h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- hsync is high when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC. vsync uses the same rule on v_cnt.
- Fetch FSM states: IDLE, ADDR (arvalid held until arready), DATA (rready=1 until the rlast beat is accepted), FLUSH.
- Burst issue condition, checked in IDLE:
  - fifo_count <= FIFO_DEPTH-BURST_LEN;
  - bursts remaining in the frame > 0;
  - no flush pending;
  - scan_enable = 1.
- Space is reserved before AR is issued, so rready never deasserts mid-burst.
- Address of pixel x on screen line y is base + 4*(H_ACTIVE*(V_ACTIVE-1-y) + x), computed modulo 2^32.
- The burst pointer walks left to right within a line. After the last burst of a line it jumps to the start of the line above in memory.
- Frame start event is the first cycle of the first vsync line. On this event:
  - set flush pending;
  - finish any outstanding burst and discard its beats;
  - enter FLUSH: clear the FIFO and reset the pointer to screen line 0;
  - return to IDLE.
- Every accepted beat pushes rdata[23:0] into the FIFO. rresp != 0 sets scan_rd_error; the data is still used.
- When the active region is reached with the FIFO non-empty, pop the FIFO and output its head.
- When the active region is reached with the FIFO empty, output vid_data = 0 and set scan_underflow.
- scan_enable low:
  - counters are held at h=0, v=V_ACTIVE+V_FP;
  - sync/de/data outputs are 0;
  - the fetcher completes any outstanding burst, then stays in IDLE;
  - both sticky flags clear.
- scan_enable rising: counting starts at h=0, v=V_ACTIVE+V_FP, so the frame start event fires immediately and prefetch runs during vertical blanking.
- Simultaneous push and pop: fifo_count is unchanged.

## Timing
- Reset values:
  - all AXI valid/ready outputs 0, araddr = base;
  - vid_* = 0, scan_underflow = 0, scan_rd_error = 0;
  - FSM in IDLE, FIFO empty.
- vid_hsync, vid_vsync, vid_de and vid_data are registered together, one cycle after the counter state that produces them.
- FIFO is first-word-fall-through; a pop takes effect in the same cycle as the output register load.
- At most one burst is outstanding. arvalid rises no earlier than one cycle after the FSM enters ADDR.
- A line lasts H_TOTAL cycles and a frame lasts H_TOTAL*V_TOTAL cycles.

## Configuration
- AXI_VIDEO_SCANOUT_GREY_EN defined:
  - each channel of vid_data = (77*R + 150*G + 29*B) >> 8;
  - the sum is an 16-bit unsigned intermediate, so the result is 8 bits;
  - this adds one pipeline register, and the sync/de outputs are delayed by one extra cycle to stay aligned.
- Macro undefined: vid_data is the raw FIFO word.

## Structure
- Package axi_video_scanout_pkg holds the fetch state enum and the fixed AXI constants (arsize, arburst, arcache).
- Sub-module video_timing_gen generates h_cnt/v_cnt, active, hsync, vsync and frame_start.
- The FIFO and the fetch FSM live in the top module.

## Test plan
Common parameters: H_ACTIVE=16, H_FP=2, H_SYNC=2, H_BP=4, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=2, BURST_LEN=4, FIFO_DEPTH=16.
- Reset held with scan_enable=1 → all outputs 0, arvalid=0.
- Enable with a zero-wait memory model → first AR has araddr = base+0xC0, arlen=3; the next AR is base+0xD0. The first de pixel equals the memory word at 0xC0 bits [23:0]. Screen line 1 starts at base+0x80.
- Free-running → hsync high for 2 cycles every 24 cycles; vsync high for 24 cycles every 192 cycles; 64 de cycles per frame.
- arready held 0 for a whole frame → vid_data=0 during de and scan_underflow=1, held until scan_enable drops.
- A beat with rresp=2'b10 → scan_rd_error=1 and the pixel is still displayed.
- With AXI_VIDEO_SCANOUT_GREY_EN, word 0x00FF0000 → vid_data=0x4C4C4C.
